// File: rtl/ysyx_23060025_axi_sram_slave_if.sv
// Reduced AXI4 bus between a master and the on-chip SRAM slave.
// Independent AW/W/B and AR/R channels carry 4-bit IDs.
interface ysyx_23060025_axi_sram_slave_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                  awvalid, awready;
    logic [ADDR_LEN-1:0]   awaddr;
    logic [3:0]            awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid, wready, wlast;
    logic [DATA_LEN-1:0]   wdata;
    logic [DATA_LEN/8-1:0] wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic [3:0]            bid;
    logic                  arvalid, arready;
    logic [ADDR_LEN-1:0]   araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid, rready, rlast;
    logic [DATA_LEN-1:0]   rdata;
    logic [1:0]            rresp;
    logic [3:0]            rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );
    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060025_axi_sram_slave.sv
// AXI4 slave terminating the core's slave port with a byte-writable register-array memory.
// Read and write FSMs are independent; one outstanding transaction per direction.
module ysyx_23060025_axi_sram_slave #(
    parameter int                  ADDR_LEN  = 32,
    parameter int                  DATA_LEN  = 32,
    parameter int                  DEPTH     = 1024,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h0f00_0000
) (
    input logic clock,
    input logic reset,
    ysyx_23060025_axi_sram_slave_if.slave s
);
    localparam int                  IDX_W = $clog2(DEPTH);
    localparam int                  NB    = DATA_LEN / 8;
    localparam logic [ADDR_LEN-1:0] SPAN  = ADDR_LEN'(4 * DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_LEN-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_LEN-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    wstate_e             w_state_q;
    logic [ADDR_LEN-1:0] waddr_q, waddr_d;
    logic [3:0]          wid_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic [2:0]          wsize_q;
    logic                wdec_q, wdec_d, wslv_q, wslv_d;
    logic                awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;
    logic [3:0]          bid_q;
    logic                w_fire, w_hit, w_last_beat;

    assign w_fire      = s.wvalid && wready_q;
    assign w_hit       = in_range(waddr_q);
    assign w_last_beat = (wcnt_q == wlen_q);
    assign waddr_d     = waddr_q + (ADDR_LEN'(1) << wsize_q);
    assign wdec_d      = wdec_q | ~w_hit;
    assign wslv_d      = wslv_q | (s.wlast != w_last_beat);

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wid_q     <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s.awvalid && awready_q) begin
                        waddr_q   <= s.awaddr;
                        wid_q     <= s.awid;
                        wlen_q    <= s.awlen;
                        wsize_q   <= s.awsize;
                        wcnt_q    <= '0;
                        wdec_q    <= 1'b0;
                        wslv_q    <= (s.awburst != 2'b01);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q <= waddr_d;
                        wcnt_q  <= wcnt_q + 8'd1;
                        wdec_q  <= wdec_d;
                        wslv_q  <= wslv_d;
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= wid_q;
                            bresp_q   <= wdec_d ? 2'b11 : (wslv_d ? 2'b10 : 2'b00);
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Out-of-range beats are dropped; the decode error is reported in B.
    always_ff @(posedge clock) begin
        if (!reset && w_fire && w_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (s.wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= s.wdata[b*8 +: 8];
            end
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.bid     = bid_q;

    // ---------------- read path ----------------
    rstate_e             r_state_q;
    logic [ADDR_LEN-1:0] raddr_q;
    logic [3:0]          rid_q;
    logic [7:0]          rlen_q, rcnt_q;
    logic [2:0]          rsize_q;
    logic                rbad_q, arready_q, rvalid_q;
    logic                r_hit, r_last_beat;

    assign r_hit       = in_range(raddr_q);
    assign r_last_beat = (rcnt_q == rlen_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rbad_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s.arvalid && arready_q) begin
                        raddr_q   <= s.araddr;
                        rid_q     <= s.arid;
                        rlen_q    <= s.arlen;
                        rsize_q   <= s.arsize;
                        rcnt_q    <= '0;
                        rbad_q    <= (s.arburst != 2'b01);
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s.rready) begin
                        raddr_q <= raddr_q + (ADDR_LEN'(1) << rsize_q);
                        rcnt_q  <= rcnt_q + 8'd1;
                        if (r_last_beat) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Read data comes straight off the array, so a same-cycle write is not yet visible.
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rid     = rid_q;
    assign s.rlast   = rvalid_q && r_last_beat;
    assign s.rdata   = (rvalid_q && r_hit) ? mem[word_idx(raddr_q)] : '0;
    assign s.rresp   = !rvalid_q ? 2'b00 : (!r_hit ? 2'b11 : (rbad_q ? 2'b10 : 2'b00));
endmodule

// File: tb/tb_ysyx_23060025_axi_sram_slave.sv
// Scoreboard bench for the AXI SRAM slave: stimulus pushes expected B/R responses,
// monitors pop and compare on every B and R handshake.
module tb_ysyx_23060025_axi_sram_slave;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_23060025_axi_sram_slave_if bus ();
    ysyx_23060025_axi_sram_slave dut (.clock(clock), .reset(reset), .s(bus));

    typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
    typedef struct {logic [1:0] resp; logic [3:0] id;} bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BASE = 32'h0f00_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus.bvalid && bus.bready) begin
            bexp_t e;
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                e = bq.pop_front();
                chk("bresp", {30'd0, bus.bresp}, {30'd0, e.resp});
                chk("bid", {28'd0, bus.bid}, {28'd0, e.id});
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && bus.rvalid && bus.rready) begin
            rexp_t e;
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                e = rq.pop_front();
                chk("rdata", bus.rdata, e.data);
                chk("rresp", {30'd0, bus.rresp}, {30'd0, e.resp});
                chk("rlast", {31'd0, bus.rlast}, {31'd0, e.last});
                chk("rid", {28'd0, bus.rid}, {28'd0, e.id});
            end
        end
    end

    task automatic aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        do begin @(negedge clock); n++; end while (!bus.awready && n < 50);
        if (!bus.awready) chk("aw_timeout", 0, 1);
        @(posedge clock); #1 bus.awvalid = 1'b0;
    endtask

    task automatic w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        do begin @(negedge clock); n++; end while (!bus.wready && n < 50);
        if (!bus.wready) chk("w_timeout", 0, 1);
        @(posedge clock); #1 bus.wvalid = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [1:0] burst);
        int n = 0;
        bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
        bus.arvalid = 1'b1;
        do begin @(negedge clock); n++; end while (!bus.arready && n < 50);
        if (!bus.arready) chk("ar_timeout", 0, 1);
        @(posedge clock); #1 bus.arvalid = 1'b0;
    endtask

    task automatic rd_beats(input int nb, input bit toggle);
        int got = 0;
        int cyc = 0;
        bus.rready = 1'b1;
        while (got < nb && cyc < 200) begin
            @(negedge clock);
            if (bus.rvalid && bus.rready) got++;
            @(posedge clock); #1;
            cyc++;
            if (toggle) bus.rready = ~bus.rready;
        end
        bus.rready = 1'b0;
        if (got < nb) chk("r_timeout", 0, 1);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                       input logic [3:0] strb, input logic [1:0] resp);
        bq.push_back('{resp, id});
        aw(a, id, 8'd0);
        w(d, strb, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
            @(posedge clock); n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 1;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctl", {18'd0, bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid,
                          bus.rlast, bus.bresp, bus.rresp, bus.bid, bus.rid}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("awready_after_reset", {31'd0, bus.awready}, 32'd1);
        chk("arready_after_reset", {31'd0, bus.arready}, 32'd1);

        // Single write then read
        bq.push_back('{2'b00, 4'd5});
        aw(BASE + 32'h10, 4'd5, 8'd0);
        chk("wready_latency", {31'd0, bus.wready}, 32'd1);
        w(32'hdeadbeef, 4'hf, 1'b1);
        drain();
        rq.push_back('{32'hdeadbeef, 2'b00, 1'b1, 4'd3});
        ar(BASE + 32'h10, 4'd3, 8'd0, 2'b01);
        chk("rvalid_latency", {31'd0, bus.rvalid}, 32'd1);
        rd_beats(1, 1'b0);
        drain();

        // Byte strobes
        wr1(BASE + 32'h20, 4'd1, 32'h11223344, 4'hf, 2'b00);
        wr1(BASE + 32'h20, 4'd2, 32'haabbccdd, 4'b0101, 2'b00);
        drain();
        rq.push_back('{32'h11bb33dd, 2'b00, 1'b1, 4'd2});
        ar(BASE + 32'h20, 4'd2, 8'd0, 2'b01);
        rd_beats(1, 1'b0);
        drain();

        // Burst with read backpressure
        bq.push_back('{2'b00, 4'd7});
        aw(BASE + 32'h100, 4'd7, 8'd3);
        for (int i = 1; i <= 4; i++) w(32'(i), 4'hf, i == 4);
        drain();
        for (int i = 1; i <= 4; i++) rq.push_back('{32'(i), 2'b00, i == 4, 4'd8});
        ar(BASE + 32'h100, 4'd8, 8'd3, 2'b01);
        rd_beats(4, 1'b1);
        drain();

        // Decode error must not alias onto word 0
        wr1(BASE, 4'd1, 32'hcafef00d, 4'hf, 2'b00);
        wr1(BASE + 32'h1000, 4'd2, 32'h55555555, 4'hf, 2'b11);
        drain();
        rq.push_back('{32'h0, 2'b11, 1'b1, 4'd2});
        ar(BASE + 32'h1000, 4'd2, 8'd0, 2'b01);
        rd_beats(1, 1'b0);
        rq.push_back('{32'hcafef00d, 2'b00, 1'b1, 4'd1});
        ar(BASE, 4'd1, 8'd0, 2'b01);
        rd_beats(1, 1'b0);
        drain();

        // Concurrent AW and AR
        bq.push_back('{2'b00, 4'd9});
        rq.push_back('{32'hdeadbeef, 2'b00, 1'b1, 4'd4});
        fork
            begin aw(BASE + 32'h200, 4'd9, 8'd0); w(32'h77, 4'hf, 1'b1); end
            begin ar(BASE + 32'h10, 4'd4, 8'd0, 2'b01); rd_beats(1, 1'b0); end
        join
        drain();

        // wlast on the wrong beat, and a non-INCR read
        bq.push_back('{2'b10, 4'd10});
        aw(BASE + 32'h40, 4'd10, 8'd1);
        w(32'h1, 4'hf, 1'b1);
        w(32'h2, 4'hf, 1'b0);
        drain();
        rq.push_back('{32'hdeadbeef, 2'b10, 1'b1, 4'd7});
        ar(BASE + 32'h10, 4'd7, 8'd0, 2'b00);
        rd_beats(1, 1'b0);
        drain();

        // Reset during beat 2 of an 8-beat read
        bq.push_back('{2'b00, 4'd11});
        aw(BASE + 32'h300, 4'd11, 8'd7);
        for (int i = 0; i < 8; i++) w(32'h30 + 32'(i), 4'hf, i == 7);
        drain();
        rq.push_back('{32'h30, 2'b00, 1'b0, 4'd6});
        rq.push_back('{32'h31, 2'b00, 1'b0, 4'd6});
        ar(BASE + 32'h300, 4'd6, 8'd7, 2'b01);
        rd_beats(2, 1'b0);
        chk("rvalid_before_reset", {31'd0, bus.rvalid}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rvalid_in_reset", {31'd0, bus.rvalid}, 32'd0);
        chk("arready_in_reset", {31'd0, bus.arready}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("arready_after_midreset", {31'd0, bus.arready}, 32'd1);
        chk("rvalid_after_midreset", {31'd0, bus.rvalid}, 32'd0);

        chk("leftover_r", rq.size(), 32'd0);
        chk("leftover_b", bq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
